// File: rtl/udp_frame_writer.sv
// udp_frame_writer: steers UDP payload bytes into the double-buffered LED-cube frame RAM.
// Port high byte picks the panel, low byte the chunk; panel 0xFF packets request a bank swap.
module udp_frame_writer #(
    parameter int PANEL_BITS = 3,
    parameter int CHUNK_BITS = 4,
    parameter int BYTE_BITS  = 8,
    localparam int AW = 1 + PANEL_BITS + CHUNK_BITS + BYTE_BITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic          s_last,
    input  logic [15:0]   s_dst_port,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          display_bank,
    output logic          swap_req,
    input  logic          swap_ack,
    output logic [15:0]   pkt_ok,
    output logic [15:0]   pkt_drop
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        DROP      = 2'd2,
        SWAP_WAIT = 2'd3
    } state_t;

    state_t                state_r, state_s;
    logic [PANEL_BITS-1:0] panel_r, panel_s;
    logic [CHUNK_BITS-1:0] chunk_r, chunk_s;
    // One extra bit so the index can sit at "one past the last byte" without wrapping.
    logic [BYTE_BITS:0]    byte_idx_r, byte_idx_s;
    logic                  bank_r, bank_s;
    logic                  ctrl_r, ctrl_s;
    logic                  ovf_r, ovf_s;
    logic                  display_bank_r, display_bank_s;
    logic                  ready_r;
    logic                  swap_req_r;
    logic                  wr_en_r, wr_en_s;
    logic [AW-1:0]         wr_addr_r, wr_addr_s;
    logic [7:0]            wr_data_r, wr_data_s;
    logic [15:0]           pkt_ok_r, pkt_ok_s;
    logic [15:0]           pkt_drop_r, pkt_drop_s;
    logic                  xfer_s, is_ctrl_s, bad_port_s;

    assign xfer_s     = s_valid & ready_r;
    assign is_ctrl_s  = (s_dst_port[15:8] == 8'hFF);
    assign bad_port_s = (|(s_dst_port[15:8] >> PANEL_BITS)) | (|(s_dst_port[7:0] >> CHUNK_BITS));

    // Next-state and next-output decode for the packet FSM.
    always_comb begin
        state_s        = state_r;
        panel_s        = panel_r;
        chunk_s        = chunk_r;
        byte_idx_s     = byte_idx_r;
        bank_s         = bank_r;
        ctrl_s         = ctrl_r;
        ovf_s          = ovf_r;
        display_bank_s = display_bank_r;
        wr_en_s        = 1'b0;
        wr_addr_s      = wr_addr_r;
        wr_data_s      = wr_data_r;
        pkt_ok_s       = pkt_ok_r;
        pkt_drop_s     = pkt_drop_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    panel_s    = s_dst_port[PANEL_BITS+7:8];
                    chunk_s    = s_dst_port[CHUNK_BITS-1:0];
                    bank_s     = ~display_bank_r;
                    ctrl_s     = is_ctrl_s;
                    ovf_s      = 1'b0;
                    byte_idx_s = {(BYTE_BITS+1){1'b0}};
                    if (is_ctrl_s) begin
                        state_s = s_last ? SWAP_WAIT : DROP;
                    end else if (bad_port_s) begin
                        if (s_last) begin
                            pkt_drop_s = pkt_drop_r + 16'd1;
                        end else begin
                            state_s = DROP;
                        end
                    end else begin
                        wr_en_s    = 1'b1;
                        wr_addr_s  = {~display_bank_r, s_dst_port[PANEL_BITS+7:8],
                                      s_dst_port[CHUNK_BITS-1:0], {BYTE_BITS{1'b0}}};
                        wr_data_s  = s_data;
                        byte_idx_s = {{BYTE_BITS{1'b0}}, 1'b1};
                        if (s_last) begin
                            pkt_ok_s = pkt_ok_r + 16'd1;
                        end else begin
                            state_s = WRITE;
                        end
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                if (xfer_s) begin
                    if (!byte_idx_r[BYTE_BITS]) begin
                        wr_en_s    = 1'b1;
                        wr_addr_s  = {bank_r, panel_r, chunk_r, byte_idx_r[BYTE_BITS-1:0]};
                        wr_data_s  = s_data;
                        byte_idx_s = byte_idx_r + {{BYTE_BITS{1'b0}}, 1'b1};
                    end else begin
                        ovf_s = 1'b1;
                    end
                    if (s_last) begin
                        state_s = IDLE;
                        if (ovf_r | byte_idx_r[BYTE_BITS]) begin
                            pkt_drop_s = pkt_drop_r + 16'd1;
                        end else begin
                            pkt_ok_s = pkt_ok_r + 16'd1;
                        end
                    end else begin
                        state_s = WRITE;
                    end
                end else begin
                    state_s = WRITE;
                end
            end
            DROP: begin
                if (xfer_s && s_last) begin
                    if (ctrl_r) begin
                        state_s = SWAP_WAIT;
                    end else begin
                        state_s    = IDLE;
                        pkt_drop_s = pkt_drop_r + 16'd1;
                    end
                end else begin
                    state_s = DROP;
                end
            end
            SWAP_WAIT: begin
                if (swap_ack) begin
                    display_bank_s = ~display_bank_r;
                    pkt_ok_s       = pkt_ok_r + 16'd1;
                    state_s        = IDLE;
                end else begin
                    state_s = SWAP_WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; s_ready/swap_req are decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            panel_r        <= {PANEL_BITS{1'b0}};
            chunk_r        <= {CHUNK_BITS{1'b0}};
            byte_idx_r     <= {(BYTE_BITS+1){1'b0}};
            bank_r         <= 1'b0;
            ctrl_r         <= 1'b0;
            ovf_r          <= 1'b0;
            display_bank_r <= 1'b0;
            ready_r        <= 1'b0;
            swap_req_r     <= 1'b0;
            wr_en_r        <= 1'b0;
            wr_addr_r      <= {AW{1'b0}};
            wr_data_r      <= 8'd0;
            pkt_ok_r       <= 16'd0;
            pkt_drop_r     <= 16'd0;
        end else begin
            state_r        <= state_s;
            panel_r        <= panel_s;
            chunk_r        <= chunk_s;
            byte_idx_r     <= byte_idx_s;
            bank_r         <= bank_s;
            ctrl_r         <= ctrl_s;
            ovf_r          <= ovf_s;
            display_bank_r <= display_bank_s;
            ready_r        <= (state_s != SWAP_WAIT);
            swap_req_r     <= (state_s == SWAP_WAIT);
            wr_en_r        <= wr_en_s;
            wr_addr_r      <= wr_addr_s;
            wr_data_r      <= wr_data_s;
            pkt_ok_r       <= pkt_ok_s;
            pkt_drop_r     <= pkt_drop_s;
        end
    end

    assign s_ready      = ready_r;
    assign swap_req     = swap_req_r;
    assign display_bank = display_bank_r;
    assign wr_en        = wr_en_r;
    assign wr_addr      = wr_addr_r;
    assign wr_data      = wr_data_r;
    assign pkt_ok       = pkt_ok_r;
    assign pkt_drop     = pkt_drop_r;

endmodule

// File: tb/tb_udp_frame_writer.sv
// Bench for udp_frame_writer: packet-level reference model feeds a write scoreboard
// that a negedge monitor drains; counters and bank state are checked per packet.
module tb_udp_frame_writer;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_last, s_ready;
    logic [15:0] s_dst_port;
    logic [7:0]  s_data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        display_bank, swap_req, swap_ack;
    logic [15:0] pkt_ok, pkt_drop;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];
    int  m_ok, m_drop, m_disp;
    bit  auto_ack = 1'b0;

    always #5 clk = ~clk;

    udp_frame_writer dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_last(s_last),
        .s_dst_port(s_dst_port), .s_data(s_data), .s_ready(s_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .display_bank(display_bank), .swap_req(swap_req), .swap_ack(swap_ack),
        .pkt_ok(pkt_ok), .pkt_drop(pkt_drop)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every frame RAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%h:%h expected=none", wr_addr, wr_data);
            end else begin
                check("wr_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
            end
        end
    end

    // Scanner stand-in: acknowledges swap requests after a random delay.
    initial begin
        swap_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_ack && swap_req) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                swap_ack = 1'b1;
                @(negedge clk);
                swap_ack = 1'b0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the beat is consumed.
    task automatic send_beat(input logic [15:0] port, input logic [7:0] data, input bit last,
                             input int gap, output int stalls);
        logic rdy;
        stalls = 0;
        repeat (gap) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1; s_dst_port = port; s_data = data; s_last = last;
        forever begin
            rdy = s_ready;
            @(posedge clk);
            if (rdy) break;
            @(negedge clk);
            stalls++;
            if (stalls > 500) begin
                checks++; errors++;
                $display("FAIL beat_timeout actual=stalled expected=accepted");
                break;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    function automatic logic [23:0] exp_wr(input int bank, input int panel, input int chunk,
                                           input int idx, input logic [7:0] d);
        int a;
        a = bank * 32768 + panel * 4096 + chunk * 256 + idx;
        return {a[15:0], d};
    endfunction

    // Reference model at packet granularity, then drive the beats and check counters.
    task automatic send_packet(input logic [15:0] port, input int len, input int gmin,
                               input int gmax, output int stall_sum);
        logic [7:0] d[$];
        int panel, chunk, st, bound;
        bit ctrl;
        panel = int'(port[15:8]);
        chunk = int'(port[7:0]);
        ctrl  = (panel == 255);
        stall_sum = 0;
        for (int i = 0; i < len; i++) d.push_back(8'($urandom));
        if (ctrl) begin
            m_disp ^= 1;
            m_ok++;
        end else if (panel >= 8 || chunk >= 16) begin
            m_drop++;
        end else begin
            for (int i = 0; i < len && i < 256; i++)
                exp_q.push_back(exp_wr(m_disp ^ 1, panel, chunk, i, d[i]));
            if (len > 256) m_drop++;
            else m_ok++;
        end
        for (int i = 0; i < len; i++) begin
            send_beat((i == 0) ? port : 16'($urandom), d[i], (i == len - 1),
                      $urandom_range(gmax, gmin), st);
            stall_sum += st;
        end
        if (ctrl) begin
            bound = 0;
            while (swap_req !== 1'b0 && bound < 200) begin
                @(negedge clk);
                bound++;
            end
            if (bound >= 200) begin
                checks++; errors++;
                $display("FAIL swap_timeout actual=%b expected=0", swap_req);
            end
        end
        check("pkt_ok", pkt_ok, 64'(16'(m_ok)));
        check("pkt_drop", pkt_drop, 64'(16'(m_drop)));
        check("display_bank", display_bank, 64'(m_disp & 1));
    endtask

    initial begin
        int st, bound;
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_dst_port = 16'd0; s_data = 8'd0;
        m_ok = 0; m_drop = 0; m_disp = 0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {s_ready, wr_en, wr_addr, wr_data, display_bank, swap_req,
                                pkt_ok, pkt_drop}, 64'd0);
        rst = 1'b0;

        // Basic 3-byte write, invalid panel, oversize packet.
        send_packet(16'h0102, 3, 0, 0, st);
        send_packet(16'h0902, 4, 0, 0, st);
        check("invalid_pkt_no_stall", st, 64'd0);
        send_packet(16'h0000, 300, 0, 0, st);

        // Control packet held off by swap handshake with s_valid asserted.
        send_beat(16'hFF00, 8'h00, 1'b1, 0, st);
        s_valid = 1'b1; s_dst_port = 16'h0102; s_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("swap_req_held", swap_req, 64'd1);
            check("ready_low_in_swap", s_ready, 64'd0);
            @(negedge clk);
        end
        swap_ack = 1'b1;
        @(negedge clk);
        swap_ack = 1'b0; s_valid = 1'b0;
        m_disp ^= 1; m_ok++;
        check("bank_after_ack", display_bank, 64'd1);
        check("swap_req_after_ack", swap_req, 64'd0);
        check("ready_after_ack", s_ready, 64'd1);
        check("ok_after_ack", pkt_ok, 64'(16'(m_ok)));
        send_packet(16'h0102, 3, 0, 0, st);

        // Throttled source: one idle cycle between beats.
        send_packet(16'h0705, 5, 1, 1, st);

        // Reset mid-packet after two beats, then a fresh packet.
        send_beat(16'h0305, 8'h11, 1'b0, 0, st);
        exp_q.push_back(exp_wr(m_disp ^ 1, 3, 5, 0, 8'h11));
        send_beat(16'h0305, 8'h22, 1'b0, 0, st);
        exp_q.push_back(exp_wr(m_disp ^ 1, 3, 5, 1, 8'h22));
        #1 rst = 1'b1;
        #1 check("midpkt_reset_outputs", {s_ready, wr_en, wr_addr, wr_data, display_bank,
                                          swap_req, pkt_ok, pkt_drop}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        m_ok = 0; m_drop = 0; m_disp = 0;
        send_packet(16'h0203, 3, 0, 0, st);

        // Randomized mix of valid, invalid, control and oversize packets.
        auto_ack = 1'b1;
        for (int n = 0; n < 30; n++) begin
            int kind, len;
            logic [15:0] port;
            kind = $urandom_range(0, 9);
            len  = ($urandom_range(0, 11) == 0) ? $urandom_range(257, 262) : $urandom_range(1, 24);
            if (kind == 0) begin
                port = {8'hFF, 8'($urandom)};
                len  = $urandom_range(1, 3);
            end else if (kind == 1) begin
                port = ($urandom_range(0, 1) == 0) ? {8'($urandom_range(8, 254)), 8'($urandom)}
                                                   : {8'($urandom_range(0, 7)), 8'($urandom_range(16, 255))};
            end else begin
                port = {8'($urandom_range(0, 7)), 8'($urandom_range(0, 15))};
            end
            send_packet(port, len, 0, 2, st);
        end

        bound = 0;
        while (exp_q.size() != 0 && bound < 50) begin
            @(negedge clk);
            bound++;
        end
        check("scoreboard_drained", exp_q.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
